// File: rtl/lcm_reg_rd_sched_if.sv
// Bus between the local control path, the LCM register-read uploader and the
// read scheduler. The scheduler takes the slave side.
interface lcm_reg_rd_sched_if;
  logic        sw_rd_req;
  logic [7:0]  sw_rd_reg_n;
  logic        poll_en;
  logic [15:0] poll_mask;
  logic [31:0] poll_interval;
  logic        out_lcm_data_ready;
  logic        lcm_valid_wr;
  logic [7:0]  rd_reg_n;
  logic        busy;
  logic        sw_pending;
  logic        sw_rej;
  logic        timeout_err;
  logic        poll_round_done;
  logic [31:0] rd_cnt;

  modport master (
    output sw_rd_req, sw_rd_reg_n, poll_en, poll_mask, poll_interval,
           out_lcm_data_ready, lcm_valid_wr,
    input  rd_reg_n, busy, sw_pending, sw_rej, timeout_err, poll_round_done,
           rd_cnt
  );

  modport slave (
    input  sw_rd_req, sw_rd_reg_n, poll_en, poll_mask, poll_interval,
           out_lcm_data_ready, lcm_valid_wr,
    output rd_reg_n, busy, sw_pending, sw_rej, timeout_err, poll_round_done,
           rd_cnt
  );
endinterface

// File: rtl/lcm_reg_rd_sched.sv
// Drives rd_reg_n of the LCM register-read uploader: software single reads take
// priority over polling rounds; each select is held for one packet, then acked.
module lcm_reg_rd_sched #(
  parameter int unsigned HOLD_CYC = 7,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned MAX_REG  = 15
) (
  input logic               clk,
  input logic               rst,
  lcm_reg_rd_sched_if.slave bus
);

  // state | meaning
  // IDLE  | nothing in flight; issue pending software read, else due poll read
  // HOLD  | rd_reg_n holds the selected index for HOLD_CYC cycles
  // ACK   | rd_reg_n = 0; wait for end-of-packet strobe or timeout
  typedef enum logic [1:0] {IDLE, HOLD, ACK} state_t;

  localparam logic [4:0] PTR_NONE = 5'd16;

  state_t      state_q;
  logic [7:0]  rd_reg_n_q;
  logic [7:0]  cnt_q;
  logic [3:0]  idx_q;
  logic        cur_poll_q;
  logic        busy_q;
  logic        sw_pending_q;
  logic [3:0]  sw_idx_q;
  logic        sw_rej_q;
  logic        timeout_err_q;
  logic        round_done_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] timer_q;
  logic        round_q;
  logic [4:0]  ptr_q;

  logic [4:0]  due_idx_d;
  logic [4:0]  nxt_idx_d;
  logic        poll_due_d;
  logic        sw_acc_d;
  logic        rnd_start_d;
  logic        done_d;

  // Lowest set mask bit at or above 'from' within [MAX_REG:1]; PTR_NONE if none.
  function automatic logic [4:0] first_set(input logic [15:0] mask,
                                           input logic [4:0]  from);
    logic [4:0] r;
    r = PTR_NONE;
    for (int i = MAX_REG; i >= 1; i--) begin
      if (mask[i] && (5'(i) >= from)) r = 5'(i);
    end
    return r;
  endfunction

  always_comb begin
    due_idx_d   = first_set(bus.poll_mask, ptr_q);
    nxt_idx_d   = first_set(bus.poll_mask, {1'b0, idx_q} + 5'd1);
    poll_due_d  = bus.poll_en && round_q && (due_idx_d != PTR_NONE);
    sw_acc_d    = bus.sw_rd_req && !sw_pending_q &&
                  (bus.sw_rd_reg_n != 8'd0) && (bus.sw_rd_reg_n <= 8'(MAX_REG));
    rnd_start_d = bus.poll_en && !round_q && (timer_q >= bus.poll_interval);
    done_d      = (state_q == ACK) && (bus.lcm_valid_wr || (cnt_q == 8'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_reg_n_q    <= 8'd0;
      cnt_q         <= 8'd0;
      idx_q         <= 4'd0;
      cur_poll_q    <= 1'b0;
      busy_q        <= 1'b0;
      sw_pending_q  <= 1'b0;
      sw_idx_q      <= 4'd0;
      sw_rej_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      round_done_q  <= 1'b0;
      rd_cnt_q      <= 32'd0;
      timer_q       <= 32'd0;
      round_q       <= 1'b0;
      ptr_q         <= 5'd1;
    end else begin
      sw_rej_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      round_done_q  <= 1'b0;

      if (bus.sw_rd_req && !sw_acc_d) sw_rej_q <= 1'b1;
      if (sw_acc_d) begin
        sw_pending_q <= 1'b1;
        sw_idx_q     <= bus.sw_rd_reg_n[3:0];
      end

      // Interval timer; an empty mask never opens a round and just restarts.
      if (bus.poll_en && !round_q) begin
        if (rnd_start_d) begin
          timer_q <= 32'd0;
          round_q <= |bus.poll_mask[MAX_REG:1];
          ptr_q   <= 5'd1;
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (bus.out_lcm_data_ready && sw_pending_q) begin
            sw_pending_q <= 1'b0;
            idx_q        <= sw_idx_q;
            rd_reg_n_q   <= {4'd0, sw_idx_q};
            cur_poll_q   <= 1'b0;
            cnt_q        <= 8'(HOLD_CYC - 1);
            busy_q       <= 1'b1;
            state_q      <= HOLD;
          end else if (bus.out_lcm_data_ready && poll_due_d && !sw_acc_d) begin
            // A software request arriving now is served first; poll waits.
            idx_q      <= due_idx_d[3:0];
            rd_reg_n_q <= {4'd0, due_idx_d[3:0]};
            cur_poll_q <= 1'b1;
            cnt_q      <= 8'(HOLD_CYC - 1);
            busy_q     <= 1'b1;
            state_q    <= HOLD;
          end
          if (round_q && (due_idx_d == PTR_NONE)) begin
            round_q <= 1'b0;
            timer_q <= 32'd0;
            ptr_q   <= 5'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            rd_reg_n_q <= 8'd0;
            cnt_q      <= 8'(TIMEOUT - 1);
            state_q    <= ACK;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ACK: begin
          if (bus.lcm_valid_wr) rd_cnt_q <= rd_cnt_q + 32'd1;
          else if (cnt_q == 8'd0) timeout_err_q <= 1'b1;
          else cnt_q <= cnt_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase

      if (done_d) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (cur_poll_q && round_q && bus.poll_en) begin
          if (nxt_idx_d == PTR_NONE) begin
            round_done_q <= 1'b1;
            round_q      <= 1'b0;
            timer_q      <= 32'd0;
            ptr_q        <= 5'd1;
          end else begin
            ptr_q <= nxt_idx_d;
          end
        end
      end

      // Dropping poll_en abandons the round; an in-flight read still completes.
      if (!bus.poll_en) begin
        round_q <= 1'b0;
        timer_q <= 32'd0;
        ptr_q   <= 5'd1;
      end
    end
  end

  assign bus.rd_reg_n        = rd_reg_n_q;
  assign bus.busy            = busy_q;
  assign bus.sw_pending      = sw_pending_q;
  assign bus.sw_rej          = sw_rej_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.poll_round_done = round_done_q;
  assign bus.rd_cnt          = rd_cnt_q;

endmodule
